register_bank_1w2r: RTL and testbench
=====================================

// Module: register_bank_1w2r
// PURPOSE
//  32-entry register bank. Sits directly downstream of the 5-to-32 one-hot write-select decoder.
//  Consumes the decoder's 32-bit one-hot vector plus write data through a one-stage write pipeline.
//  Serves two combinational read ports. Register 0 is hardwired to zero.
//  Screens malformed select vectors (zero-hot or multi-hot) and reports them via a sticky error flag.
// PARAMETERS
//  DATA_WIDTH   32   width of each register and of the write/read data buses
//  RESET_VALUE  0    value loaded into registers 1..31 on reset (DATA_WIDTH bits)
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous, active-low reset
//  wr_valid_i   in   1           write request strobe, sampled each rising edge
//  wr_onehot_i  in   32          one-hot register select from the decoder
//  wr_data_i    in   DATA_WIDTH  write data
//  rd_addr_a_i  in   5           read port A address
//  rd_data_a_o  out  DATA_WIDTH  read port A data (combinational)
//  rd_addr_b_i  in   5           read port B address
//  rd_data_b_o  out  DATA_WIDTH  read port B data (combinational)
//  pend_o       out  1           a captured write is waiting to commit
//  err_clr_i    in   1           synchronous clear of err_o
//  err_o        out  1           sticky malformed-select flag
// BEHAVIOUR
//  - Reset (rst_n=0, async): regs 1..31 <= RESET_VALUE; pend_valid <= 0; pend_onehot, pend_data <= 0;
//    err_o <= 0. A pending write is discarded. Reads still operate combinationally during reset.
//  - Stage W (capture), at edge N with wr_valid_i=1 and wr_onehot_i exactly one-hot:
//    pend_onehot <= wr_onehot_i; pend_data <= wr_data_i; pend_valid <= 1.
//  - Stage W, malformed request (wr_valid_i=1, popcount != 1): pend_valid <= 0; err_o <= 1.
//  - Stage W, wr_valid_i=0: pend_valid <= 0.
//  - Stage C (commit), at edge N+1 if pend_valid: reg[i] <= pend_data for the single set bit i.
//    Bit 0 set: commit is dropped silently; this is not an error.
//  - Back-to-back requests: sustains one write per cycle; capture and commit overlap each edge.
//  - Write-to-read latency without bypass: data is visible on reads after edge N+1.
//  - pend_o = pend_valid.
//  - Reads: rd_data_x_o = (rd_addr_x_i==0) ? 0 : reg[rd_addr_x_i]. The two ports are independent.
//    Both ports may address the same register.
//  - err_o is sticky. err_clr_i=1 clears it at the next edge. If a clear and a new malformed
//    request arrive on the same edge, set wins.
//  - Popcount check uses (v!=0) && ((v & (v-1))==0) on 32 bits. X-free for all 2^32 inputs.
// CONFIGURATION
//  REGBANK_BYPASS_EN defined:
//   - Read ports forward pend_data when pend_valid && pend_onehot[rd_addr] && rd_addr!=0.
//   - Effective write-to-read latency becomes 1 edge (visible after edge N).
//   - Forwarding takes priority over the array contents.
//  REGBANK_BYPASS_EN undefined:
//   - No forwarding; reads return array contents only.
//   - A read of a pending register returns the old value until commit.
// TESTING
//  1. Reset values: assert rst_n=0 mid-cycle, RESET_VALUE=0.
//     -> all reads return 0; pend_o=0; err_o=0 immediately, without waiting for a clock.
//  2. Basic write: wr_onehot_i=32'h0000_0020, wr_data_i=32'hDEAD_BEEF at edge 1.
//     -> pend_o=1 after edge 1.
//     -> rd_addr_a_i=5 reads 32'hDEAD_BEEF after edge 2, or after edge 1 with REGBANK_BYPASS_EN.
//  3. Zero register: write 32'h1234_5678 with onehot=32'h1.
//     -> rd addr 0 returns 0 on both ports; err_o stays 0.
//  4. Malformed select: onehot=32'h0000_0006 at edge 1.
//     -> err_o=1 after edge 1; regs 1 and 2 unchanged; pend_o=0.
//     Then onehot=0 with wr_valid_i=1 while err_clr_i=1 -> err_o remains 1 (set wins).
//  5. Back-to-back: write reg3=32'hA, reg3=32'hB, reg7=32'hC on consecutive edges.
//     -> after final commit, reg3=32'hB, reg7=32'hC.
//     -> port A (addr 3) and port B (addr 7) show the correct per-cycle values under both configs.
//  6. Reset mid-operation: capture write reg9=32'h55, then pull rst_n low before the commit edge.
//     -> reg9 reads RESET_VALUE; pend_o=0.

Source files
------------

// File: rtl/register_bank_1w2r.sv
// register_bank_1w2r
//   32-entry register bank fed by a 5-to-32 one-hot write-select decoder.
//   Writes pass through one capture stage (W) and commit on the following
//   edge (C); two independent combinational read ports; register 0 reads zero.
//   Malformed select vectors (zero-hot or multi-hot) set a sticky error flag.
//   Optional feature macro: REGBANK_BYPASS_EN forwards the pending write
//   data to the read ports so a write is visible one edge earlier.
module register_bank_1w2r #(
    parameter int unsigned             DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid_i,
    input  logic [31:0]           wr_onehot_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [4:0]            rd_addr_a_i,
    output logic [DATA_WIDTH-1:0] rd_data_a_o,
    input  logic [4:0]            rd_addr_b_i,
    output logic [DATA_WIDTH-1:0] rd_data_b_o,
    output logic                  pend_o,
    input  logic                  err_clr_i,
    output logic                  err_o
);

    logic [DATA_WIDTH-1:0] regs [1:31];
    logic [DATA_WIDTH-1:0] mem_view [0:31];

    logic                  pend_valid;
    logic [31:0]           pend_onehot;
    logic [DATA_WIDTH-1:0] pend_data;
    logic                  sel_ok;

    // Exactly-one-bit-set test; pure combinational arithmetic, X-free for known inputs.
    assign sel_ok = (wr_onehot_i != 32'd0) &&
                    ((wr_onehot_i & (wr_onehot_i - 32'd1)) == 32'd0);

    assign pend_o = pend_valid;

    // Stage W: capture a well-formed request; anything else leaves nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid  <= 1'b0;
            pend_onehot <= '0;
            pend_data   <= '0;
        end else if (wr_valid_i && sel_ok) begin
            pend_valid  <= 1'b1;
            pend_onehot <= wr_onehot_i;
            pend_data   <= wr_data_i;
        end else begin
            pend_valid  <= 1'b0;
        end
    end

    // Stage C: commit the pending write; a select of register 0 is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else if (pend_valid && !pend_onehot[0]) begin
            for (int i = 1; i < 32; i++) begin
                if (pend_onehot[i]) begin
                    regs[i] <= pend_data;
                end
            end
        end
    end

    // Sticky malformed-select flag; a new error outranks a same-edge clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if (wr_valid_i && !sel_ok) begin
            err_o <= 1'b1;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end

    // Full 32-entry read view with entry 0 tied to zero.
    always_comb begin
        mem_view[0] = '0;
        for (int i = 1; i < 32; i++) begin
            mem_view[i] = regs[i];
        end
    end

    // Read port A, optionally forwarding the not-yet-committed write.
    always_comb begin
        rd_data_a_o = mem_view[rd_addr_a_i];
`ifdef REGBANK_BYPASS_EN
        if (pend_valid && pend_onehot[rd_addr_a_i] && (rd_addr_a_i != 5'd0)) begin
            rd_data_a_o = pend_data;
        end
`endif
    end

    // Read port B, same structure as port A and fully independent of it.
    always_comb begin
        rd_data_b_o = mem_view[rd_addr_b_i];
`ifdef REGBANK_BYPASS_EN
        if (pend_valid && pend_onehot[rd_addr_b_i] && (rd_addr_b_i != 5'd0)) begin
            rd_data_b_o = pend_data;
        end
`endif
    end

endmodule

// File: tb/tb_register_bank_1w2r.sv
// tb_register_bank_1w2r
//   Directed bench for register_bank_1w2r. Expected values are queued as
//   stimulus is driven and popped when the corresponding output is sampled
//   (1 time unit after the rising edge, or mid-cycle for reset checks).
module tb_register_bank_1w2r;

    localparam int DW = 32;

`ifdef REGBANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          wr_valid_i;
    logic [31:0]   wr_onehot_i;
    logic [DW-1:0] wr_data_i;
    logic [4:0]    rd_addr_a_i;
    logic [DW-1:0] rd_data_a_o;
    logic [4:0]    rd_addr_b_i;
    logic [DW-1:0] rd_data_b_o;
    logic          pend_o;
    logic          err_clr_i;
    logic          err_o;

    register_bank_1w2r #(
        .DATA_WIDTH  (DW),
        .RESET_VALUE ('0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid_i  (wr_valid_i),
        .wr_onehot_i (wr_onehot_i),
        .wr_data_i   (wr_data_i),
        .rd_addr_a_i (rd_addr_a_i),
        .rd_data_a_o (rd_data_a_o),
        .rd_addr_b_i (rd_addr_b_i),
        .rd_data_b_o (rd_data_b_o),
        .pend_o      (pend_o),
        .err_clr_i   (err_clr_i),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_underflow observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] oh, input logic [31:0] d);
        wr_valid_i  = v;
        wr_onehot_i = oh;
        wr_data_i   = d;
    endtask

    initial begin
        rst_n       = 1'b1;
        wr_valid_i  = 1'b0;
        wr_onehot_i = '0;
        wr_data_i   = '0;
        rd_addr_a_i = 5'd4;
        rd_addr_b_i = 5'd31;
        err_clr_i   = 1'b0;

        // 1. asynchronous reset asserted mid-cycle, outputs checked before any edge
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        expect_val("rst_rd_a", 32'h0);
        expect_val("rst_rd_b", 32'h0);
        expect_val("rst_pend", 32'h0);
        expect_val("rst_err",  32'h0);
        check(rd_data_a_o);
        check(rd_data_b_o);
        check({31'd0, pend_o});
        check({31'd0, err_o});
        @(negedge clk);
        rst_n = 1'b1;

        // 2. basic write to reg5
        rd_addr_a_i = 5'd5;
        drive(1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
        expect_val("bw_pend_e1", 32'h1);
        expect_val("bw_rd_e1", BYP ? 32'hDEAD_BEEF : 32'h0);
        tick();
        check({31'd0, pend_o});
        check(rd_data_a_o);
        drive(1'b0, '0, '0);
        expect_val("bw_pend_e2", 32'h0);
        expect_val("bw_rd_e2", 32'hDEAD_BEEF);
        tick();
        check({31'd0, pend_o});
        check(rd_data_a_o);

        // 3. write to register 0 is dropped, no error
        rd_addr_a_i = 5'd0;
        rd_addr_b_i = 5'd0;
        drive(1'b1, 32'h0000_0001, 32'h1234_5678);
        expect_val("z_pend", 32'h1);
        expect_val("z_rd_a_e1", 32'h0);
        expect_val("z_rd_b_e1", 32'h0);
        tick();
        check({31'd0, pend_o});
        check(rd_data_a_o);
        check(rd_data_b_o);
        drive(1'b0, '0, '0);
        expect_val("z_rd_a_e2", 32'h0);
        expect_val("z_rd_b_e2", 32'h0);
        expect_val("z_err", 32'h0);
        tick();
        check(rd_data_a_o);
        check(rd_data_b_o);
        check({31'd0, err_o});

        // 4. malformed selects; preload reg1/reg2 so "unchanged" is meaningful
        rd_addr_a_i = 5'd1;
        rd_addr_b_i = 5'd2;
        drive(1'b1, 32'h0000_0002, 32'h0000_0011);
        tick();
        drive(1'b1, 32'h0000_0004, 32'h0000_0022);
        tick();
        drive(1'b1, 32'h0000_0006, 32'hFFFF_FFFF);
        expect_val("mf_err", 32'h1);
        expect_val("mf_pend", 32'h0);
        tick();
        check({31'd0, err_o});
        check({31'd0, pend_o});
        drive(1'b0, '0, '0);
        expect_val("mf_reg1", 32'h0000_0011);
        expect_val("mf_reg2", 32'h0000_0022);
        tick();
        check(rd_data_a_o);
        check(rd_data_b_o);
        drive(1'b1, 32'h0, 32'h0);
        err_clr_i = 1'b1;
        expect_val("mf_set_wins", 32'h1);
        expect_val("mf_zero_pend", 32'h0);
        tick();
        check({31'd0, err_o});
        check({31'd0, pend_o});
        drive(1'b0, '0, '0);
        expect_val("mf_clear", 32'h0);
        tick();
        check({31'd0, err_o});
        err_clr_i = 1'b0;

        // 5. back-to-back writes reg3=A, reg3=B, reg7=C
        rd_addr_a_i = 5'd3;
        rd_addr_b_i = 5'd7;
        drive(1'b1, 32'h0000_0008, 32'hA);
        expect_val("bb_a_e1", BYP ? 32'hA : 32'h0);
        expect_val("bb_b_e1", 32'h0);
        tick();
        check(rd_data_a_o);
        check(rd_data_b_o);
        drive(1'b1, 32'h0000_0008, 32'hB);
        expect_val("bb_a_e2", BYP ? 32'hB : 32'hA);
        expect_val("bb_b_e2", 32'h0);
        tick();
        check(rd_data_a_o);
        check(rd_data_b_o);
        drive(1'b1, 32'h0000_0080, 32'hC);
        expect_val("bb_a_e3", 32'hB);
        expect_val("bb_b_e3", BYP ? 32'hC : 32'h0);
        tick();
        check(rd_data_a_o);
        check(rd_data_b_o);
        drive(1'b0, '0, '0);
        expect_val("bb_a_e4", 32'hB);
        expect_val("bb_b_e4", 32'hC);
        expect_val("bb_err", 32'h0);
        tick();
        check(rd_data_a_o);
        check(rd_data_b_o);
        check({31'd0, err_o});

        // 6. reset between capture and commit discards the pending write
        rd_addr_a_i = 5'd9;
        rd_addr_b_i = 5'd5;
        drive(1'b1, 32'h0000_0200, 32'h55);
        expect_val("rm_pend_cap", 32'h1);
        tick();
        check({31'd0, pend_o});
        drive(1'b0, '0, '0);
        #2 rst_n = 1'b0;
        #1;
        expect_val("rm_pend", 32'h0);
        expect_val("rm_reg9", 32'h0);
        expect_val("rm_reg5", 32'h0);
        check({31'd0, pend_o});
        check(rd_data_a_o);
        check(rd_data_b_o);
        @(negedge clk);
        rst_n = 1'b1;
        expect_val("rm_reg9_after", 32'h0);
        tick();
        check(rd_data_a_o);

        if (sb.size() != 0) begin
            miscompares++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
